// File: rtl/feedback_stream_packer.sv
// -----------------------------------------------------------------------------
// feedback_stream_packer
//
// Purpose:
//   Downstream sink for the kernel1/kernel2 feedback top. It takes the 1-bit
//   result stream (n4_w) and throws away the first SKIP enabled bits, which are
//   the feedback-loop fill latency. It then packs the remaining bits LSB-first
//   into WIDTH-bit words. Completed words go into a DEPTH-entry
//   first-word-fall-through FIFO, which the HIL host/collector drains over a
//   ready/valid interface.
//
// Parameters:
//   WIDTH  bits per packed word (>= 2)
//   SKIP   enabled cycles discarded after reset (0 allowed)
//   DEPTH  FIFO depth in words (power of 2, >= 2)
//
// Ports:
//   clock       system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   w           result bit from the feedback top
//   enable      bit qualifier; w is sampled only when 1
//   out_data    FIFO head word (0 after reset, holds last value when empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word
//   count       FIFO occupancy
//   overflow    sticky flag: a completed word was dropped because FIFO was full
//   clear_ovf   clears overflow (a simultaneous drop wins)
//   out_parity  XOR of the head word bits (only with the parity macro)
//
// Optional feature:
//   Define FEEDBACK_STREAM_PACKER_PARITY_EN to add out_parity. The parity bit
//   is computed when a word is pushed and is stored next to that word in the
//   FIFO.
// -----------------------------------------------------------------------------
module feedback_stream_packer #(
    parameter int WIDTH = 8,
    parameter int SKIP  = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       w,
    input  logic                       enable,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
`ifdef FEEDBACK_STREAM_PACKER_PARITY_EN
    output logic                       out_parity,
`endif
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clear_ovf
);

    // -------------------------------------------------------------------------
    // Local parameters and types
    // -------------------------------------------------------------------------
    localparam int CW  = $clog2(DEPTH + 1);               // occupancy width
    localparam int PW  = $clog2(DEPTH);                   // pointer width
    localparam int BW  = $clog2(WIDTH);                   // bit-counter width
    localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

`ifdef FEEDBACK_STREAM_PACKER_PARITY_EN
    localparam int EW = WIDTH + 1;                         // {parity, word}
`else
    localparam int EW = WIDTH;
`endif

    localparam logic [SKW-1:0] SKIP_LAST = SKW'(SKIP - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [CW-1:0]  COUNT_MAX = CW'(DEPTH);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_PACK   = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Packer state
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [SKW-1:0]   r_skip_cnt;
    logic [BW-1:0]    r_bitcnt;
    // Only the lower WIDTH-1 bits are stored. The final bit goes straight
    // from w into the pushed word.
    logic [WIDTH-2:0] r_shift;

    logic             w_push;
    logic [WIDTH-1:0] w_word;
    logic [EW-1:0]    w_entry;

    // -------------------------------------------------------------------------
    // FIFO state
    // -------------------------------------------------------------------------
    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic [EW-1:0]    r_head;
    logic             r_ovf;

    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic             w_drop;
    logic [PW-1:0]    w_rptr_next;
    logic [CW-1:0]    w_remain;
    logic [CW-1:0]    w_count_next;
    logic [EW-1:0]    w_head_next;

    // -------------------------------------------------------------------------
    // Word assembly
    // -------------------------------------------------------------------------
    // The word completes on the enabled PACK cycle that samples bit WIDTH-1.
    // It is pushed at that same edge, so there is no extra register stage.
    assign w_push = (r_state == ST_PACK) && enable && (r_bitcnt == BIT_LAST);
    assign w_word = {w, r_shift};

`ifdef FEEDBACK_STREAM_PACKER_PARITY_EN
    assign w_entry = {^w_word, w_word};
`else
    assign w_entry = w_word;
`endif

    // Warm-up / pack FSM. enable=0 freezes every register in this block.
    // NOTE: sequential state is written with non-blocking (<=) assignments, so
    // every register here samples pre-edge values no matter the statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= (SKIP == 0) ? ST_PACK : ST_WARMUP;
            r_skip_cnt <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
        end else if (enable) begin
            case (r_state)
                ST_WARMUP: begin
                    // w is ignored while the feedback loop fills.
                    r_skip_cnt <= r_skip_cnt + SKW'(1);
                    if (r_skip_cnt == SKIP_LAST) begin
                        r_state <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    // The first data bit lands in bit 0 (LSB-first).
                    for (int i = 0; i < WIDTH - 1; i++) begin
                        if (r_bitcnt == BW'(i)) begin
                            r_shift[i] <= w;
                        end
                    end
                    // Wrap with no bubble: the next enabled cycle is bit 0.
                    if (r_bitcnt == BIT_LAST) begin
                        r_bitcnt <= '0;
                    end else begin
                        r_bitcnt <= r_bitcnt + BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_WARMUP;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FIFO control
    // -------------------------------------------------------------------------
    assign w_pop  = r_valid && out_ready;
    assign w_full = (r_count == COUNT_MAX);
    // A push into a full FIFO succeeds only if the head leaves in the same cycle.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // The head word and valid flag are registered. They are loaded with what
    // the FIFO will present after this edge: the next stored entry if one
    // remains after a pop, otherwise the word being pushed into an empty FIFO.
    // NOTE: every signal driven in this always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_count_next = r_count;
        w_rptr_next  = r_rptr;
        w_remain     = r_count;
        w_head_next  = r_head;

        if (w_wr && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_wr && w_pop) begin
            w_count_next = r_count - CW'(1);
        end

        if (w_pop) begin
            w_rptr_next = r_rptr + PW'(1);
            w_remain    = r_count - CW'(1);
        end

        if (w_remain != '0) begin
            w_head_next = r_mem[w_rptr_next];
        end else if (w_wr) begin
            w_head_next = w_entry;
        end
    end

    // NOTE: the storage array is not reset. Validity comes from the pointers
    // and count, so clearing the array would add reset fan-out and buy nothing.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
            r_head  <= w_head_next;
            // A drop in the same cycle as clear_ovf leaves the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_data  = r_head[WIDTH-1:0];
    assign out_valid = r_valid;
    assign count     = r_count;
    assign overflow  = r_ovf;

`ifdef FEEDBACK_STREAM_PACKER_PARITY_EN
    assign out_parity = r_head[WIDTH];
`endif

endmodule
